mailbox_apb_port: RTL and testbench
===================================

Name: mailbox_apb_port

Overview:
APB3 slave front-end that converts a CPU fabric APB transfer into the level-held read/write strobe protocol of one mailbox controller side (a_* or b_*). One instance per side sits between the fabric interconnect and the mailbox controller. It holds a strobe until the controller's ready arrives, then enforces a recovery gap so a stale ready is never taken for the next access. Misaligned or out-of-window addresses and timeouts are returned as PSLVERR.

Parameters:
APB_ADDR_W, 8, width of paddr; bits above [5:0] must be zero for a valid access.
TIMEOUT_CYCLES, 16, strobe cycles without mbx_ready before the access is aborted with an error; legal range 2..255.

Ports:
clk  in  1  block clock (APB and mailbox share it)
resetn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  APB direction, 1 = write
paddr  in  APB_ADDR_W  APB byte address
pwdata  in  32  APB write data
pready  out  1  APB ready, registered
prdata  out  32  APB read data, registered
pslverr  out  1  APB error, registered
mbx_write  out  1  write strobe to mailbox controller, level-held
mbx_read  out  1  read strobe to mailbox controller, level-held
mbx_addr  out  6  word-aligned mailbox offset
mbx_wdata  out  32  write data to mailbox controller
mbx_ready  in  1  completion from mailbox controller (read valid or write valid)
mbx_rdata  in  32  read data from controller; valid only while mbx_ready=1

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; pready, pslverr, mbx_write, mbx_read=0; prdata, mbx_addr, mbx_wdata, timeout counter=0.
- FSM states: IDLE, REQ, RESP, RECOVER.
- IDLE: on psel=1 and penable=0 (setup phase), latch pwrite, paddr[5:0], pwdata into mbx_addr/mbx_wdata.
  - Address error if paddr[1:0]!=0 or paddr[APB_ADDR_W-1:6]!=0: go to RESP with err=1. No strobe is issued.
  - Otherwise assert mbx_write=pwrite and mbx_read=!pwrite on the next edge, clear the counter, and go to REQ.
- REQ: the strobe stays high.
  - mbx_ready=1: capture prdata<=mbx_rdata for reads (0 for writes), drop the strobe, err=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1, drop the strobe, set err=1, prdata=0, go to RESP.
  - Timeout therefore completes TIMEOUT_CYCLES cycles after strobe assertion.
- RESP: pready=1 for exactly one cycle; pslverr=err, and it is valid only in that cycle. Next state is RECOVER. pready and pslverr return to 0 the following cycle, and prdata is cleared to 0.
- RECOVER: strobes stay low. Remain in RECOVER while mbx_ready=1; go to IDLE on the first cycle with mbx_ready=0. Minimum one cycle.
- Latency, good access with a 1-cycle controller:
  - setup edge -> strobe (T+1)
  - mbx_ready (T+2)
  - pready (T+3)
  - the next setup is accepted no earlier than T+5.
- pready is held 0 in IDLE, REQ and RECOVER. An APB master in the access phase therefore waits.
- psel dropped while in REQ (protocol violation): the downstream access completes normally and the response is issued but ignored. There is no abort and no strobe glitch.
- Strobes are mutually exclusive and never both 1. mbx_addr and mbx_wdata are stable for the whole time a strobe is high.
- Assertion of resetn mid-REQ immediately drops strobes and pready. The controller sees the strobe fall and clears its own valid.
- The counter saturates and never wraps. Its width is ceil(log2(TIMEOUT_CYCLES)).

Decomposition:
- mailbox_pkg holds:
  - the state enum (IDLE/REQ/RESP/RECOVER)
  - MBX_ADDR_W=6 and MBX_DATA_W=32
  - register offset constants: VERSION=0x00, CTRL=0x04, PEER_HART=0x08, DEPTH=0x0C, RD_MSG base=0x20, WR_MSG base=0x30
- No sub-module: the FSM, the counter and the capture registers stay in one file.

Test Plan:
- Write paddr=0x30, pwdata=0xDEADBEEF, controller ready 1 cycle after the strobe -> mbx_write=1 with mbx_addr=0x30 and mbx_wdata=0xDEADBEEF held until ready; pready=1, pslverr=0 exactly once; mbx_read never 1.
- Read paddr=0x00, controller returns mbx_rdata=0x00000001 with ready -> prdata=0x00000001 and pslverr=0 in the pready cycle; prdata=0 the cycle after.
- Read paddr=0x08 with mbx_ready tied 0 -> strobe high for exactly 16 cycles, then pready=1, pslverr=1, prdata=0.
- Write paddr=0x41 (misaligned) and paddr=0x80 (above window) -> pready=1, pslverr=1, mbx_write and mbx_read stay 0 throughout.
- Back-to-back reads to 0x20 then 0x24, controller ready held 1 cycle after the strobe falls -> second strobe not asserted until mbx_ready=0; the second prdata matches the second mbx_rdata only.
- Assert resetn low during REQ -> mbx_read, pready and pslverr become 0 asynchronously; after release, state is IDLE and a new access completes normally.

Source files
------------

// File: rtl/mailbox_pkg.sv
// mailbox_pkg: shared constants for the mailbox APB port (state encoding, widths, register map).
// Rev 1.0
`default_nettype none

package mailbox_pkg;

  localparam int MBX_ADDR_W = 6;
  localparam int MBX_DATA_W = 32;

  typedef logic [1:0] mbx_state_t;

  localparam mbx_state_t ST_IDLE    = 2'd0;
  localparam mbx_state_t ST_REQ     = 2'd1;
  localparam mbx_state_t ST_RESP    = 2'd2;
  localparam mbx_state_t ST_RECOVER = 2'd3;

  localparam logic [MBX_ADDR_W-1:0] OFS_VERSION   = 6'h00;
  localparam logic [MBX_ADDR_W-1:0] OFS_CTRL      = 6'h04;
  localparam logic [MBX_ADDR_W-1:0] OFS_PEER_HART = 6'h08;
  localparam logic [MBX_ADDR_W-1:0] OFS_DEPTH     = 6'h0C;
  localparam logic [MBX_ADDR_W-1:0] OFS_RD_MSG    = 6'h20;
  localparam logic [MBX_ADDR_W-1:0] OFS_WR_MSG    = 6'h30;

endpackage

`default_nettype wire

// File: rtl/mailbox_apb_port.sv
// mailbox_apb_port: APB3 slave that turns one transfer into a level-held mailbox strobe.
// Rev 1.0
`default_nettype none

module mailbox_apb_port
  import mailbox_pkg::*;
#(
  parameter int APB_ADDR_W     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [MBX_DATA_W-1:0] pwdata,
  output logic                  pready,
  output logic [MBX_DATA_W-1:0] prdata,
  output logic                  pslverr,
  output logic                  mbx_write,
  output logic                  mbx_read,
  output logic [MBX_ADDR_W-1:0] mbx_addr,
  output logic [MBX_DATA_W-1:0] mbx_wdata,
  input  logic                  mbx_ready,
  input  logic [MBX_DATA_W-1:0] mbx_rdata
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mbx_state_t              state_q, state_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [MBX_DATA_W-1:0]   prdata_q, prdata_d;
  logic                    write_q, write_d;
  logic                    read_q, read_d;
  logic [MBX_ADDR_W-1:0]   addr_q, addr_d;
  logic [MBX_DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic setup_w;
  logic addr_err_w;

  assign setup_w    = psel & ~penable;
  // Only word-aligned offsets inside the 64-byte window reach the controller.
  assign addr_err_w = (paddr[1:0] != 2'b00) | (|(paddr >> MBX_ADDR_W));

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    write_d   = write_q;
    read_d    = read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (setup_w) begin
          addr_d  = paddr[MBX_ADDR_W-1:0];
          wdata_d = pwdata;
          if (addr_err_w) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            state_d   = ST_RESP;
          end else begin
            write_d = pwrite;
            read_d  = ~pwrite;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mbx_ready) begin
          prdata_d = read_q ? mbx_rdata : '0;
          write_d  = 1'b0;
          read_d   = 1'b0;
          pready_d = 1'b1;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          write_d   = 1'b0;
          read_d    = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        prdata_d = '0;
        state_d  = ST_RECOVER;
      end

      // A ready still high here belongs to the access just finished.
      ST_RECOVER: begin
        if (!mbx_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign mbx_write = write_q;
  assign mbx_read  = read_q;
  assign mbx_addr  = addr_q;
  assign mbx_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mailbox_apb_port.sv
// tb_mailbox_apb_port: directed self-checking bench for mailbox_apb_port.
// Rev 1.0
`default_nettype none

module tb_mailbox_apb_port;
  import mailbox_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        mbx_write, mbx_read;
  logic [5:0]  mbx_addr;
  logic [31:0] mbx_wdata;
  logic        mbx_ready;
  logic [31:0] mbx_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rhold    = 0;
  int rd_seen = 0, wr_seen = 0, both_seen = 0, pready_cnt = 0;

  always #5 clk = ~clk;

  mailbox_apb_port #(.APB_ADDR_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .mbx_write(mbx_write), .mbx_read(mbx_read), .mbx_addr(mbx_addr), .mbx_wdata(mbx_wdata),
    .mbx_ready(mbx_ready), .mbx_rdata(mbx_rdata)
  );

  always @(negedge clk) begin
    if (mbx_read)              rd_seen    <= rd_seen + 1;
    if (mbx_write)             wr_seen    <= wr_seen + 1;
    if (mbx_read && mbx_write) both_seen  <= both_seen + 1;
    if (pready)                pready_cnt <= pready_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer with a scripted controller: ready rises once the strobe has been
  // high for more than lat cycles (lat=0: never), then stays high hold cycles past pready.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input int lat, input int hold,
                      input logic [31:0] rd, input int exp_setup, input int exp_sc,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int n, sc;
    logic stable;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (rhold > 0) rhold--;
      mbx_ready = (rhold > 0);
    end while (!(mbx_read || mbx_write || pready) && n < 20);
    check_eq({tag, ".setup_cycles"}, 32'(n), 32'(exp_setup));

    penable = 1'b1;
    sc = 0; stable = 1'b1; n = 0;
    while (!pready && n < 100) begin
      if (mbx_read || mbx_write) begin
        sc++;
        if (mbx_addr !== addr[5:0] || mbx_wdata !== wd || mbx_write !== wr || mbx_read !== !wr)
          stable = 1'b0;
      end
      mbx_ready = (lat > 0) && (sc > lat);
      mbx_rdata = mbx_ready ? rd : 32'hBAD0_BAD0;
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, ".pready"},        32'(pready), 32'd1);
    check_eq({tag, ".strobe_cycles"}, 32'(sc), 32'(exp_sc));
    check_eq({tag, ".strobe_stable"}, 32'(stable), 32'd1);
    check_eq({tag, ".pslverr"},       32'(pslverr), 32'(exp_err));
    check_eq({tag, ".prdata"},        prdata, exp_rdata);
    check_eq({tag, ".strobe_low"},    32'(mbx_read | mbx_write), 32'd0);

    psel = 1'b0; penable = 1'b0;
    rhold = hold;
    mbx_ready = (rhold > 0);
    @(posedge clk); #1;
    if (rhold > 0) rhold--;
    mbx_ready = (rhold > 0);
    check_eq({tag, ".pready_after"},  32'(pready), 32'd0);
    check_eq({tag, ".pslverr_after"}, 32'(pslverr), 32'd0);
    check_eq({tag, ".prdata_after"},  prdata, 32'd0);
    check_eq({tag, ".strobe_after"},  32'(mbx_read | mbx_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, w0;
    resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; mbx_ready = 1'b0; mbx_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.pready",    32'(pready), 32'd0);
    check_eq("rst.pslverr",   32'(pslverr), 32'd0);
    check_eq("rst.strobes",   32'({mbx_read, mbx_write}), 32'd0);
    check_eq("rst.prdata",    prdata, 32'd0);
    check_eq("rst.mbx_addr",  32'(mbx_addr), 32'd0);
    check_eq("rst.mbx_wdata", mbx_wdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    p0 = pready_cnt; r0 = rd_seen;
    xfer("wr30", 1'b1, 8'h30, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 2, 1'b0, 32'h0);
    check_eq("wr30.pready_pulses", 32'(pready_cnt - p0), 32'd1);
    check_eq("wr30.no_read",       32'(rd_seen - r0), 32'd0);

    xfer("rd00", 1'b0, {2'b00, OFS_VERSION}, 32'h0, 1, 0, 32'h0000_0001, 2, 2, 1'b0, 32'h0000_0001);
    xfer("rd08_timeout", 1'b0, {2'b00, OFS_PEER_HART}, 32'h0, 0, 0, 32'h1234_5678, 2, 16, 1'b1, 32'h0);

    r0 = rd_seen; w0 = wr_seen;
    xfer("wr41", 1'b1, 8'h41, 32'hCAFE_0001, 1, 0, 32'h0, 2, 0, 1'b1, 32'h0);
    xfer("wr80", 1'b1, 8'h80, 32'hCAFE_0002, 1, 0, 32'h0, 2, 0, 1'b1, 32'h0);
    check_eq("addr_err.no_strobe", 32'((rd_seen - r0) + (wr_seen - w0)), 32'd0);

    xfer("rd20", 1'b0, {2'b00, OFS_RD_MSG}, 32'h0, 1, 2, 32'h1111_1111, 2, 2, 1'b0, 32'h1111_1111);
    xfer("rd24", 1'b0, 8'h24, 32'h0, 1, 0, 32'h2222_2222, 3, 2, 1'b0, 32'h2222_2222);
    xfer("rd0c_lat3", 1'b0, {2'b00, OFS_DEPTH}, 32'h5555_AAAA, 3, 0, 32'hA5A5_5A5A, 2, 4, 1'b0, 32'hA5A5_5A5A);

    // Reset in the middle of a read strobe.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C; mbx_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_req.strobe_up", 32'(mbx_read), 32'd1);
    penable = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_req.read",    32'(mbx_read), 32'd0);
    check_eq("rst_req.pready",  32'(pready), 32'd0);
    check_eq("rst_req.pslverr", 32'(pslverr), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    xfer("wr04_after_rst", 1'b1, {2'b00, OFS_CTRL}, 32'h0000_00F0, 2, 0, 32'h0, 1, 3, 1'b0, 32'h0);

    check_eq("strobes_exclusive", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
